// File: rtl/traffic_pkg.sv
// Shared traffic-light types and constants: phase encoding, segment patterns,
// default phase lengths common to the light controller and its displays.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_XGO   = 2'd1,
        PH_YGO   = 2'd2,
        PH_FAULT = 2'd3
    } phase_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Any code 10..15 decodes to a dark digit; used for leading-zero suppression.
    localparam logic [3:0] BCD_BLANK = 4'hF;

    localparam int unsigned DEF_TX_SEC = 30;
    localparam int unsigned DEF_TY_SEC = 15;

    function automatic logic [7:0] to_bcd(input int unsigned sec);
        return {4'(sec / 10), 4'(sec % 10)};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; codes 10..15 are dark.
module seg7_decode
    import traffic_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg_n
);

    always_comb begin
        o_seg_n = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg_n = 7'h40;
            4'd1:    o_seg_n = 7'h79;
            4'd2:    o_seg_n = 7'h24;
            4'd3:    o_seg_n = 7'h30;
            4'd4:    o_seg_n = 7'h19;
            4'd5:    o_seg_n = 7'h12;
            4'd6:    o_seg_n = 7'h02;
            4'd7:    o_seg_n = 7'h78;
            4'd8:    o_seg_n = 7'h00;
            4'd9:    o_seg_n = 7'h10;
            default: o_seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_display.sv
// Right-of-way countdown on a 4-digit multiplexed common-anode display (X: digits 1:0, Y: 3:2).
// Define COUNTDOWN_BLINK_EN to blink the digits during the last five seconds of a phase.
module countdown_display
    import traffic_pkg::*;
#(
    parameter int unsigned TX_SEC        = DEF_TX_SEC,
    parameter int unsigned TY_SEC        = DEF_TY_SEC,
    parameter int unsigned TICKS_PER_SEC = 10,
    parameter int unsigned SCAN_DIV      = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_en,
    input  logic       rx,
    input  logic       ry,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic [1:0] phase
);

    localparam int unsigned SUB_W  = $clog2(TICKS_PER_SEC);
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [7:0] LOAD_X = to_bcd(TX_SEC);
    localparam logic [7:0] LOAD_Y = to_bcd(TY_SEC);

    phase_t              r_phase;
    phase_t              w_phase_nxt;
    logic                w_counting;
    logic [3:0]          r_tens;
    logic [3:0]          r_ones;
    logic [3:0]          w_tens_dec;
    logic [3:0]          w_ones_dec;
    logic [SUB_W-1:0]    r_sub;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [1:0]          r_idx;
    logic [3:0]          w_digit;
    logic [6:0]          w_dec_seg;
    logic [6:0]          w_seg_nxt;

    // Phase FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_IDLE;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Phase FSM: next state follows the controller lamps every clock.
    always_comb begin
        w_phase_nxt = PH_IDLE;
        case ({rx, ry})
            2'b00: w_phase_nxt = PH_IDLE;
            2'b01: w_phase_nxt = PH_XGO;
            2'b10: w_phase_nxt = PH_YGO;
            2'b11: w_phase_nxt = PH_FAULT;
        endcase
    end

    // Phase FSM: outputs and display content for the digit currently selected.
    always_comb begin
        phase      = r_phase;
        w_counting = (r_phase == PH_XGO) || (r_phase == PH_YGO);
        w_seg_nxt  = SEG_BLANK;
        case (r_phase)
            PH_XGO, PH_YGO: begin
                w_seg_nxt = w_dec_seg;
`ifdef COUNTDOWN_BLINK_EN
                if ((r_tens == 4'd0) && (r_ones <= 4'd5) &&
                    (r_sub >= SUB_W'(TICKS_PER_SEC / 2)))
                    w_seg_nxt = SEG_BLANK;
`endif
            end
            PH_FAULT: w_seg_nxt = SEG_DASH;
            default:  w_seg_nxt = SEG_BLANK;
        endcase
    end

    // Saturating BCD decrement: 00 holds rather than wrapping.
    always_comb begin
        w_tens_dec = r_tens;
        w_ones_dec = r_ones;
        if (r_ones != 4'd0) begin
            w_ones_dec = r_ones - 4'd1;
        end else if (r_tens != 4'd0) begin
            w_ones_dec = 4'd9;
            w_tens_dec = r_tens - 4'd1;
        end
    end

    // A phase change reloads the count and wins over a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tens <= '0;
            r_ones <= '0;
            r_sub  <= '0;
        end else if (w_phase_nxt != r_phase) begin
            r_sub <= '0;
            case (w_phase_nxt)
                PH_XGO:  {r_tens, r_ones} <= LOAD_X;
                PH_YGO:  {r_tens, r_ones} <= LOAD_Y;
                default: {r_tens, r_ones} <= '0;
            endcase
        end else if (w_counting && tick_en) begin
            if (r_sub == SUB_LAST) begin
                r_sub  <= '0;
                r_tens <= w_tens_dec;
                r_ones <= w_ones_dec;
            end else begin
                r_sub <= r_sub + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Both roads show the same count; odd digits are tens, dark when zero.
    always_comb begin
        w_digit = r_ones;
        if (r_idx[0])
            w_digit = (r_tens == 4'd0) ? BCD_BLANK : r_tens;
    end

    seg7_decode u_seg7_decode (
        .i_bcd   (w_digit),
        .o_seg_n (w_dec_seg)
    );

    // Anode and segments registered together so a digit never shows its neighbour's pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n  <= 4'b1110;
            seg_n <= SEG_BLANK;
        end else begin
            an_n  <= ~(4'b0001 << r_idx);
            seg_n <= w_seg_nxt;
        end
    end

endmodule

// File: tb/tb_countdown_display.sv
// Directed bench for countdown_display: every-cycle comparison against a seconds-level model
// plus hand-computed digit patterns at chosen points of each phase.
module tb_countdown_display;

    localparam int TX    = 30;
    localparam int TY    = 15;
    localparam int TICKS = 10;
    localparam int SDIV  = 1;
`ifdef COUNTDOWN_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_en;
    logic       rx;
    logic       ry;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic [1:0] phase;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_no = 0;
    int base    = 0;

    countdown_display #(
        .TX_SEC        (TX),
        .TY_SEC        (TY),
        .TICKS_PER_SEC (TICKS),
        .SCAN_DIV      (SDIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_en (tick_en),
        .rx      (rx),
        .ry      (ry),
        .an_n    (an_n),
        .seg_n   (seg_n),
        .phase   (phase)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    // Model state: phase number, whole seconds left, ticks into the second, scan position.
    int         m_ph, m_secs, m_sub, m_idx, m_scnt;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    function automatic logic [6:0] show(input int ph, input int secs, input int sub, input int idx);
        if (ph == 0) return 7'h7F;
        if (ph == 3) return 7'h3F;
        if (BLINK && secs <= 5 && sub >= TICKS / 2) return 7'h7F;
        if (idx % 2 == 0) return seg_of(secs % 10);
        return (secs / 10 == 0) ? 7'h7F : seg_of(secs / 10);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int np, ns, nsub;
        if (!rst_n) begin
            m_ph <= 0; m_secs <= 0; m_sub <= 0; m_idx <= 0; m_scnt <= 0;
            m_an <= 4'b1110; m_seg <= 7'h7F;
        end else begin
            np   = rx * 2 + ry;
            ns   = m_secs;
            nsub = m_sub;
            if (np != m_ph) begin
                ns   = (np == 1) ? TX : (np == 2) ? TY : 0;
                nsub = 0;
            end else if ((m_ph == 1 || m_ph == 2) && tick_en) begin
                if (m_sub == TICKS - 1) begin
                    nsub = 0;
                    if (m_secs > 0) ns = m_secs - 1;
                end else begin
                    nsub = m_sub + 1;
                end
            end
            m_seg  <= show(m_ph, m_secs, m_sub, m_idx);
            m_an   <= ~(4'b0001 << m_idx);
            m_scnt <= (m_scnt == SDIV - 1) ? 0 : m_scnt + 1;
            m_idx  <= (m_scnt == SDIV - 1) ? (m_idx + 1) % 4 : m_idx;
            m_ph   <= np;
            m_secs <= ns;
            m_sub  <= nsub;
        end
    end

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("phase", {5'd0, phase}, 7'(m_ph));
        check("an_n", {3'd0, an_n}, {3'd0, m_an});
        check("seg_n", seg_n, m_seg);
    end

    task automatic check_digit(input int idx, input logic [6:0] exp, input string name);
        logic [3:0] want;
        bit found;
        want  = ~(4'b0001 << idx);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            if (an_n == want) begin
                found = 1'b1;
                check(name, seg_n, exp);
            end
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: digit %0d never selected, an_n=%b", name, idx, an_n);
        end
    endtask

    // New controller state applied now; the next clock edge is phase-relative edge 0.
    task automatic drive(input logic x, input logic y);
        rx   = x;
        ry   = y;
        base = edge_no;
    endtask

    task automatic wait_t(input int t);
        while (edge_no - base - 1 < t) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; tick_en = 1'b0; rx = 1'b0; ry = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_an", {3'd0, an_n}, 7'b0001110);
            check("rst_seg", seg_n, 7'h7F);
            check("rst_phase", {5'd0, phase}, 7'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_phase", {5'd0, phase}, 7'd0);

        // X phase with tick_en high on the entry clock: entry still shows 30.
        tick_en = 1'b1;
        drive(1'b0, 1'b1);
        @(negedge clk);
        check("x_phase", {5'd0, phase}, 7'd1);
        wait_t(2);
        check_digit(0, 7'h40, "x30_ones");
        check_digit(1, 7'h30, "x30_tens");
        wait_t(12);
        check_digit(0, 7'h10, "x29_ones");
        check_digit(1, 7'h24, "x29_tens");
        wait_t(212);
        check_digit(0, 7'h10, "x09_ones");
        check_digit(1, 7'h7F, "x09_tens_blank");
        wait_t(305);
        check_digit(0, 7'h40, "x00_ones");
        check_digit(1, 7'h7F, "x00_tens_blank");
        check_digit(2, 7'h40, "y_disp00_ones");
        wait_t(321);
        check_digit(0, 7'h40, "x00_held");

        drive(1'b1, 1'b1);
        @(negedge clk);
        check("fault_phase", {5'd0, phase}, 7'd3);
        @(negedge clk);
        for (int d = 0; d < 4; d++) check_digit(d, 7'h3F, "fault_dash");

        drive(1'b0, 1'b1);
        @(negedge clk);
        check("x_reentry_phase", {5'd0, phase}, 7'd1);
        wait_t(3);
        check_digit(0, 7'h40, "reload30_ones");
        check_digit(1, 7'h30, "reload30_tens");
        wait_t(183);
        check_digit(0, 7'h24, "x12_ones");
        check_digit(1, 7'h79, "x12_tens");

        drive(1'b1, 1'b0);
        @(negedge clk);
        check("y_phase", {5'd0, phase}, 7'd2);
        @(negedge clk);
        check_digit(0, 7'h12, "y15_ones");
        check_digit(1, 7'h79, "y15_tens");
        check_digit(2, 7'h12, "y15_ones_ydig");
        check_digit(3, 7'h79, "y15_tens_ydig");

        repeat (37) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_an", {3'd0, an_n}, 7'b0001110);
        check("midrst_seg", seg_n, 7'h7F);
        check("midrst_phase", {5'd0, phase}, 7'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base  = edge_no;
        @(negedge clk);
        check("rerst_phase", {5'd0, phase}, 7'd2);
        @(negedge clk);
        check_digit(0, 7'h12, "rerst_y15_ones");
        check_digit(1, 7'h79, "rerst_y15_tens");

        drive(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("idle_again", {5'd0, phase}, 7'd0);
        check_digit(0, 7'h7F, "idle_blank");

        // Last five seconds: the display reflects the state one edge earlier.
        drive(1'b0, 1'b1);
        wait_t(250);
        for (int k = 0; k < 10; k++) begin
            int s;
            @(negedge clk);
            s = edge_no - base - 2;
            if (an_n == 4'b1110)
                check("x05_ones", seg_n, (BLINK && (s % 10) >= 5) ? 7'h7F : 7'h12);
        end
        wait_t(310);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
